// File: rtl/i2s_dac_tx_if.sv
// ---------------------------------------------------------------------------
// i2s_dac_tx_if
// Sample handshake between the effect datapath and the I2S DAC serializer.
//
// Signals:
//   dac_left     - left channel word (two's complement)
//   dac_right    - right channel word (two's complement)
//   sample_valid - datapath offers a stereo pair
//   sample_ready - serializer holding register is empty
//
// Modports:
//   master - datapath side (drives samples, observes ready)
//   slave  - serializer side (consumes samples, drives ready)
// ---------------------------------------------------------------------------
interface i2s_dac_tx_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] dac_left;
    logic [DATA_WIDTH-1:0] dac_right;
    logic                  sample_valid;
    logic                  sample_ready;

    modport master (
        output dac_left,
        output dac_right,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  dac_left,
        input  dac_right,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/i2s_dac_tx.sv
// ---------------------------------------------------------------------------
// i2s_dac_tx
// Serializes one stereo PCM pair per audio frame onto the codec DAC data pin
// in I2S format. The codec is clock master; AUD_BCLK and aud_lrck are
// oversampled in the CLOCK_50 domain and data leaves MSB-first with the
// standard one-bit delay after each LR clock edge.
//
// Parameters:
//   DATA_WIDTH  - bits per channel word
//   SYNC_STAGES - synchronizer depth on AUD_BCLK and aud_lrck (>= 2)
//
// Ports:
//   CLOCK_50    - system clock, sole clock of the block
//   reset_n     - asynchronous active-low reset
//   AUD_BCLK    - codec bit clock (asynchronous)
//   aud_lrck    - codec DAC LR clock, 0 = left, 1 = right (asynchronous)
//   smp         - sample handshake (dac_left, dac_right, sample_valid,
//                 sample_ready)
//   AUD_DACDAT  - serial DAC data
//   frame_start - one-cycle pulse when a left word is loaded
//   underrun    - one-cycle pulse when a frame starts with no pair held
// ---------------------------------------------------------------------------
module i2s_dac_tx #(
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    input  logic        AUD_BCLK,
    input  logic        aud_lrck,
    i2s_dac_tx_if.slave smp,
    output logic        AUD_DACDAT,
    output logic        frame_start,
    output logic        underrun
);

    typedef enum logic [1:0] {
        WAIT_SYNC,
        LEFT,
        RIGHT
    } state_t;

    state_t                  state;
    state_t                  state_next;

    logic [SYNC_STAGES-1:0]  bclk_sync;
    logic [SYNC_STAGES-1:0]  lrck_sync;
    logic                    bclk_s;
    logic                    lrck_s;
    logic                    bclk_q;
    logic                    bclk_fall;
    logic                    lrck_prev;
    logic                    left_start;
    logic                    right_start;

    logic                    hold_full;
    logic [DATA_WIDTH-1:0]   hold_left;
    logic [DATA_WIDTH-1:0]   hold_right;
    logic [DATA_WIDTH-1:0]   shreg;
    logic [DATA_WIDTH-1:0]   right_buf;

    // Bring both codec clocks into the CLOCK_50 domain. bclk_q is one more
    // register on the synchronized bit clock so a falling edge can be seen
    // as "was high, now low". Everything resets to 0 so a high pin at
    // release shows up as a rising edge, never a fall.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            bclk_q    <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], AUD_BCLK};
            lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], aud_lrck};
            bclk_q    <= bclk_sync[SYNC_STAGES-1];
        end
    end

    assign bclk_s    = bclk_sync[SYNC_STAGES-1];
    assign lrck_s    = lrck_sync[SYNC_STAGES-1];
    assign bclk_fall = bclk_q & ~bclk_s;

    // LR clock edges are only judged at bit clock falls, against the value
    // seen at the previous fall. A right start is only honoured once we are
    // locked onto a left word, which is what makes the startup 0->1 edge
    // harmless.
    assign left_start  = bclk_fall & lrck_prev & ~lrck_s;
    assign right_start = bclk_fall & ~lrck_prev & lrck_s & (state == LEFT);

    // Remember the LR clock level at each bit clock fall.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            lrck_prev <= 1'b0;
        end else if (bclk_fall) begin
            lrck_prev <= lrck_s;
        end
    end

    // Holding register toward the datapath. A left start empties it; ready
    // is low whenever it is full, so a fresh pair cannot land in the same
    // cycle it is being consumed and is taken one cycle later instead.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            hold_full  <= 1'b0;
            hold_left  <= '0;
            hold_right <= '0;
        end else if (left_start && hold_full) begin
            hold_full <= 1'b0;
        end else if (smp.sample_valid && !hold_full) begin
            hold_full  <= 1'b1;
            hold_left  <= smp.dac_left;
            hold_right <= smp.dac_right;
        end
    end

    assign smp.sample_ready = ~hold_full;

    // Frame state register.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= WAIT_SYNC;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A left start wins from any state, even in the middle
    // of a short half-frame, so the truncated word is simply abandoned.
    always_comb begin
        state_next = state;
        case (state)
            WAIT_SYNC: begin
                if (left_start) begin
                    state_next = LEFT;
                end
            end
            LEFT: begin
                if (left_start) begin
                    state_next = LEFT;
                end else if (right_start) begin
                    state_next = RIGHT;
                end
            end
            RIGHT: begin
                if (left_start) begin
                    state_next = LEFT;
                end
            end
            default: begin
                state_next = WAIT_SYNC;
            end
        endcase
    end

    // Shift register and serial output. The fall that loads a word drives 0
    // (the I2S delay slot); each later fall presents the current MSB and
    // shifts in a zero, so once the word is exhausted the rest of the
    // half-frame is 0. An underrun loads zeros for both channels so the
    // whole frame is silent.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            shreg       <= '0;
            right_buf   <= '0;
            AUD_DACDAT  <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= left_start;
            underrun    <= left_start & ~hold_full;
            if (left_start) begin
                shreg      <= hold_full ? hold_left  : '0;
                right_buf  <= hold_full ? hold_right : '0;
                AUD_DACDAT <= 1'b0;
            end else if (right_start) begin
                shreg      <= right_buf;
                AUD_DACDAT <= 1'b0;
            end else if (bclk_fall && (state != WAIT_SYNC)) begin
                AUD_DACDAT <= shreg[DATA_WIDTH-1];
                shreg      <= {shreg[DATA_WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// ---------------------------------------------------------------------------
// tb_i2s_dac_tx
// Bench for i2s_dac_tx. The bench plays the codec (drives AUD_BCLK and
// aud_lrck) and the datapath (offers sample pairs). A frame-level model
// decides, at every LR clock edge, which word belongs in the half-frame and
// queues the bit expected in every slot; a monitor pops one expected bit at
// each rising bit clock edge, where the codec would sample.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_i2s_dac_tx;

    localparam int DW    = 16;
    localparam int BHALF = 160;

    logic CLOCK_50 = 1'b0;
    logic reset_n;
    logic AUD_BCLK;
    logic aud_lrck;
    logic AUD_DACDAT;
    logic frame_start;
    logic underrun;

    i2s_dac_tx_if #(.DATA_WIDTH(DW)) bus ();

    i2s_dac_tx #(
        .DATA_WIDTH (DW),
        .SYNC_STAGES(2)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset_n    (reset_n),
        .AUD_BCLK   (AUD_BCLK),
        .aud_lrck   (aud_lrck),
        .smp        (bus),
        .AUD_DACDAT (AUD_DACDAT),
        .frame_start(frame_start),
        .underrun   (underrun)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int total     = 0;
    int bad       = 0;
    int got_frame = 0;
    int got_under = 0;
    int exp_frame = 0;
    int exp_under = 0;

    logic [2*DW-1:0] pending[$];
    bit              exp_bits[$];
    bit              mon_exp;
    bit              mon_en    = 1'b0;
    bit              near_edge = 1'b0;
    bit              stim_done = 1'b0;

    bit              m_prev_lr = 1'b0;
    int              m_half    = 0;
    logic [DW-1:0]   m_rbuf    = '0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Codec-side check: one expected bit per rising bit clock edge.
    always @(posedge AUD_BCLK) begin
        if (mon_en) begin
            if (exp_bits.size() == 0) begin
                checkOutput("bit_queue_underflow", 1, 0);
            end else begin
                mon_exp = exp_bits.pop_front();
                checkOutput("dacdat_slot", int'(AUD_DACDAT), int'(mon_exp));
            end
        end
    end

    // Pulse counters for frame_start and underrun.
    always @(negedge CLOCK_50) begin
        if (frame_start === 1'b1) got_frame++;
        if (underrun === 1'b1) got_under++;
    end

    // Datapath side: offer one pair and wait for it to be taken. While the
    // holding register is empty, a pair is not raised right around a left
    // edge so the model knows which frame it belongs to.
    task automatic applyStimulus(input logic [DW-1:0] l, input logic [DW-1:0] r);
        int waited;
        waited = 0;
        while (near_edge && bus.sample_ready && waited < 4000) begin
            @(negedge CLOCK_50);
            waited++;
        end
        bus.dac_left     = l;
        bus.dac_right    = r;
        bus.sample_valid = 1'b1;
        while (!bus.sample_ready && waited < 4000) begin
            @(negedge CLOCK_50);
            waited++;
        end
        if (waited >= 4000) begin
            checkOutput("accept_timeout", waited, 0);
            bus.sample_valid = 1'b0;
            return;
        end
        pending.push_back({l, r});
        @(negedge CLOCK_50);
        checkOutput("ready_after_accept", int'(bus.sample_ready), 0);
        bus.sample_valid = 1'b0;
    endtask

    // Puts the codec pins 3 ns after a CLOCK_50 rising edge.
    task automatic alignCodec();
        @(negedge CLOCK_50);
        #13;
    endtask

    // One half-frame of len bit clocks at LR level lr. The model picks the
    // word from the frame rules and queues every slot's bit. rst_slot >= 0
    // pulses reset during that slot.
    task automatic runHalf(input int len, input bit lr, input int rst_slot);
        logic [DW-1:0]   word;
        logic [2*DW-1:0] pair;
        bit              eb[$];
        word = '0;
        if (m_prev_lr && !lr) begin
            exp_frame++;
            m_half = 1;
            if (pending.size() > 0) begin
                pair   = pending.pop_front();
                word   = pair[2*DW-1:DW];
                m_rbuf = pair[DW-1:0];
            end else begin
                exp_under++;
                m_rbuf = '0;
            end
        end else if (!m_prev_lr && lr && m_half == 1) begin
            word   = m_rbuf;
            m_half = 2;
        end
        m_prev_lr = lr;
        for (int s = 0; s < len; s++) begin
            if (s >= 1 && s <= DW && (rst_slot < 0 || s < rst_slot)) eb.push_back(word[DW-s]);
            else eb.push_back(1'b0);
        end
        foreach (eb[i]) exp_bits.push_back(eb[i]);

        for (int s = 0; s < len; s++) begin
            AUD_BCLK = 1'b0;
            if (s == 0) aud_lrck = lr;
            if (lr && s == len - 1) near_edge = 1'b1;
            if (!lr && s == 1) near_edge = 1'b0;
            if (s == rst_slot) begin
                #100;
                checkOutput("ready_before_reset", int'(bus.sample_ready), (pending.size() > 0) ? 0 : 1);
                reset_n = 1'b0;
                #1;
                checkOutput("dacdat_async_reset", int'(AUD_DACDAT), 0);
                checkOutput("ready_async_reset", int'(bus.sample_ready), 1);
                pending.delete();
                m_half    = 0;
                m_prev_lr = 1'b0;
                m_rbuf    = '0;
                #39;
                reset_n = 1'b1;
                #20;
            end else if (s >= 1 && rst_slot < 0 && eb[s] != eb[s-1]) begin
                #50;
                checkOutput("latency_old_bit", int'(AUD_DACDAT), int'(eb[s-1]));
                #10;
                checkOutput("latency_new_bit", int'(AUD_DACDAT), int'(eb[s]));
                #100;
            end else begin
                #BHALF;
            end
            AUD_BCLK = 1'b1;
            #BHALF;
        end
    endtask

    task automatic checkCounts(input string tag);
        checkOutput({tag, "_frame_starts"}, got_frame, exp_frame);
        checkOutput({tag, "_underruns"}, got_under, exp_under);
    endtask

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation did not complete, got %0d expected 0 remaining bits", exp_bits.size());
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int frames;
        reset_n          = 1'b0;
        AUD_BCLK         = 1'b1;
        aud_lrck         = 1'b1;
        bus.sample_valid = 1'b0;
        bus.dac_left     = '0;
        bus.dac_right    = '0;
        repeat (3) @(negedge CLOCK_50);
        checkOutput("reset_dacdat", int'(AUD_DACDAT), 0);
        checkOutput("reset_ready", int'(bus.sample_ready), 1);
        checkOutput("reset_frame_start", int'(frame_start), 0);
        checkOutput("reset_underrun", int'(underrun), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge CLOCK_50);

        $display("[TB] startup, basic frame and underrun");
        mon_en = 1'b1;
        applyStimulus(16'hA5C3, 16'h8001);
        alignCodec();
        runHalf(16, 1'b1, -1);
        runHalf(32, 1'b0, -1);
        runHalf(32, 1'b1, -1);
        runHalf(32, 1'b0, -1);
        runHalf(32, 1'b1, -1);
        checkCounts("basic");

        $display("[TB] continuous handshake");
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    applyStimulus(16'(16'h1000 + i * 16'h0111), 16'(16'h2000 + i * 16'h0123));
                end
            end
            begin
                alignCodec();
                repeat (8) begin
                    runHalf(32, 1'b0, -1);
                    runHalf(32, 1'b1, -1);
                end
            end
        join
        checkOutput("handshake_all_consumed", pending.size(), 0);
        checkCounts("handshake");

        $display("[TB] short half-frames");
        fork
            applyStimulus(16'hB38E, 16'h6D21);
            begin
                alignCodec();
                runHalf(32, 1'b0, -1);
                runHalf(32, 1'b1, -1);
                runHalf(8, 1'b0, -1);
                runHalf(8, 1'b1, -1);
                runHalf(32, 1'b0, -1);
                runHalf(32, 1'b1, -1);
            end
        join
        checkCounts("short");

        $display("[TB] randomized frames and samples");
        stim_done = 1'b0;
        frames    = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    repeat ($urandom_range(0, 150)) @(negedge CLOCK_50);
                    applyStimulus(16'($urandom), 16'($urandom));
                end
                stim_done = 1'b1;
            end
            begin
                alignCodec();
                while ((!stim_done || pending.size() > 0) && frames < 40) begin
                    runHalf(int'($urandom_range(8, 40)), 1'b0, -1);
                    runHalf(int'($urandom_range(8, 40)), 1'b1, -1);
                    frames++;
                end
                runHalf(32, 1'b0, -1);
                runHalf(32, 1'b1, -1);
            end
        join
        checkOutput("random_all_consumed", pending.size(), 0);
        checkCounts("random");

        $display("[TB] reset in the middle of a word");
        fork
            begin
                applyStimulus(16'hF00D, 16'h7E57);
                applyStimulus(16'h1234, 16'h5678);
            end
            begin
                alignCodec();
                runHalf(32, 1'b0, -1);
                runHalf(32, 1'b1, -1);
                runHalf(32, 1'b0, 5);
                runHalf(32, 1'b1, -1);
                runHalf(32, 1'b0, -1);
                runHalf(32, 1'b1, -1);
            end
        join
        checkCounts("reset");

        repeat (4) @(negedge CLOCK_50);
        checkOutput("bits_left_unchecked", exp_bits.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
